interrupt_spr_unit: RTL and testbench

//  Interrupt-cause masking, priority encoding and special-purpose register (SPR) file in one block.

---
 rtl/interrupt_spr_unit_pkg.sv | 41 ++++
 rtl/interrupt_spr_unit_ic_prio.sv | 45 ++++
 rtl/interrupt_spr_unit.sv | 131 +++++++++++++
 tb/tb_interrupt_spr_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_spr_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_spr_unit_pkg
// Description : Shared constants for the interrupt / SPR unit. Holds the
//               cause-line geometry, the SPR index map and the cause indices.
//               It also provides a helper that widens the masked causes into
//               the 32-bit ECA image.
// Revision    : 1.0 - initial release
// ============================================================================
package interrupt_spr_unit_pkg;

    // Cause-line geometry
    localparam int NCAUSE    = 23;   // cause lines 0..22
    localparam int FIRST_MSK = 6;    // causes below this index ignore SR

    // SPR index map (spr_addr encoding)
    localparam logic [2:0] SPR_SR    = 3'd0;
    localparam logic [2:0] SPR_ESR   = 3'd1;
    localparam logic [2:0] SPR_ECA   = 3'd2;
    localparam logic [2:0] SPR_EPC   = 3'd3;
    localparam logic [2:0] SPR_EDATA = 3'd4;
    localparam logic [2:0] SPR_PTO   = 3'd5;
    localparam logic [2:0] SPR_PTL   = 3'd6;
    localparam logic [2:0] SPR_MODE  = 3'd7;

    // Cause indices (22:7 are external interrupts)
    localparam int CA_RESET = 0;
    localparam int CA_ILL   = 1;
    localparam int CA_MAL   = 2;
    localparam int CA_PFF   = 3;
    localparam int CA_PFLS  = 4;
    localparam int CA_SYSC  = 5;
    localparam int CA_OVF   = 6;

    // Zero-extend the masked cause vector into the 32-bit ECA image.
    function automatic logic [31:0] eca_image(input logic [NCAUSE-1:0] mca);
        return {{(32-NCAUSE){1'b0}}, mca};
    endfunction

endpackage : interrupt_spr_unit_pkg
`default_nettype wire

// File: rtl/interrupt_spr_unit_ic_prio.sv
`default_nettype none
// ============================================================================
// Module      : ic_prio
// Description : Combinational cause masking, interrupt request and priority
//               encoding. Causes below FIRST_MSK pass straight through. The
//               rest are gated by the matching SR bit.
// Ports       : ca      in  NCAUSE            raw cause lines
//               sr_msk  in  NCAUSE-FIRST_MSK  SR bits for the maskable causes
//               mca     out NCAUSE            masked causes
//               jisr    out 1                 any masked cause pending
//               il      out 5                 lowest pending index (0 if none)
// Revision    : 1.0 - initial release
// ============================================================================
module ic_prio
    import interrupt_spr_unit_pkg::*;
(
    input  logic [NCAUSE-1:0]         ca,
    input  logic [NCAUSE-1:FIRST_MSK] sr_msk,
    output logic [NCAUSE-1:0]         mca,
    output logic                      jisr,
    output logic [4:0]                il
);

    for (genvar j = 0; j < NCAUSE; j++) begin : g_mask
        if (j < FIRST_MSK) begin : g_fixed
            assign mca[j] = ca[j];
        end else begin : g_masked
            assign mca[j] = ca[j] & sr_msk[j];
        end
    end

    assign jisr = |mca;

    // Scan from the top down so that the lowest set index wins (0 = highest priority).
    always_comb begin
        il = '0;
        for (int j = NCAUSE - 1; j >= 0; j--) begin
            if (mca[j]) begin
                il = 5'(j);
            end
        end
    end

endmodule : ic_prio
`default_nettype wire

// File: rtl/interrupt_spr_unit.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_spr_unit
// Description : Interrupt-cause masking plus the special-purpose register
//               file. A taken interrupt (jisr) saves SR/cause/PC/EA into the
//               exception registers and enters system mode on the same edge.
//               eret restores SR from ESR and enters user mode. spr_we
//               performs a movg2s write. Priority is jisr > eret > spr_we.
// Ports       : clk, rst_n (async, active-low)
//               ca[22:0], pc, next_pc, ea, rpt      interrupt context
//               eret, spr_we, spr_addr, spr_wdata   SPR control
//               spr_rdata                           comb read of SPR[spr_addr]
//               sr_out..ptl, mode_out               SPR contents
//               mca, jisr, il                       masked causes / request
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_spr_unit
    import interrupt_spr_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCAUSE-1:0] ca,
    input  logic [31:0]       pc,
    input  logic [31:0]       next_pc,
    input  logic [31:0]       ea,
    input  logic              rpt,
    input  logic              eret,
    input  logic              spr_we,
    input  logic [2:0]        spr_addr,
    input  logic [31:0]       spr_wdata,
    output logic [31:0]       spr_rdata,
    output logic [31:0]       sr_out,
    output logic [31:0]       esr_out,
    output logic [31:0]       eca_out,
    output logic [31:0]       epc_out,
    output logic [31:0]       edata_out,
    output logic [31:0]       pto,
    output logic [31:0]       ptl,
    output logic              mode_out,
    output logic [NCAUSE-1:0] mca,
    output logic              jisr,
    output logic [4:0]        il
);

    logic [31:0]       r_sr;
    logic [31:0]       r_esr;
    logic [31:0]       r_eca;
    logic [31:0]       r_epc;
    logic [31:0]       r_edata;
    logic [31:0]       r_pto;
    logic [31:0]       r_ptl;
    logic              r_mode;

    logic [NCAUSE-1:0] w_mca;
    logic              w_jisr;
    logic [4:0]        w_il;

    // Masking always sees the current SR. A new SR only takes effect next cycle.
    ic_prio u_ic_prio (
        .ca     (ca),
        .sr_msk (r_sr[NCAUSE-1:FIRST_MSK]),
        .mca    (w_mca),
        .jisr   (w_jisr),
        .il     (w_il)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr    <= '0;
            r_esr   <= '0;
            r_eca   <= '0;
            r_epc   <= '0;
            r_edata <= '0;
            r_pto   <= '0;
            r_ptl   <= '0;
            r_mode  <= 1'b0;
        end else if (w_jisr) begin
            // Interrupt entry: any eret / spr_we in the same cycle is dropped.
            r_esr   <= r_sr;
            r_sr    <= '0;
            r_eca   <= eca_image(w_mca);
            r_epc   <= rpt ? pc : next_pc;
            r_edata <= ea;
            r_mode  <= 1'b0;
        end else if (eret) begin
            r_sr    <= r_esr;
            r_mode  <= 1'b1;
        end else if (spr_we) begin
            case (spr_addr)
                SPR_SR:    r_sr    <= spr_wdata;
                SPR_ESR:   r_esr   <= spr_wdata;
                SPR_ECA:   r_eca   <= spr_wdata;  // software may set the upper bits
                SPR_EPC:   r_epc   <= spr_wdata;
                SPR_EDATA: r_edata <= spr_wdata;
                SPR_PTO:   r_pto   <= spr_wdata;
                SPR_PTL:   r_ptl   <= spr_wdata;
                SPR_MODE:  r_mode  <= spr_wdata[0];
                default:   r_mode  <= r_mode;
            endcase
        end
    end

    always_comb begin
        spr_rdata = '0;
        case (spr_addr)
            SPR_SR:    spr_rdata = r_sr;
            SPR_ESR:   spr_rdata = r_esr;
            SPR_ECA:   spr_rdata = r_eca;
            SPR_EPC:   spr_rdata = r_epc;
            SPR_EDATA: spr_rdata = r_edata;
            SPR_PTO:   spr_rdata = r_pto;
            SPR_PTL:   spr_rdata = r_ptl;
            SPR_MODE:  spr_rdata = {31'b0, r_mode};
            default:   spr_rdata = '0;
        endcase
    end

    assign sr_out    = r_sr;
    assign esr_out   = r_esr;
    assign eca_out   = r_eca;
    assign epc_out   = r_epc;
    assign edata_out = r_edata;
    assign pto       = r_pto;
    assign ptl       = r_ptl;
    assign mode_out  = r_mode;
    assign mca       = w_mca;
    assign jisr      = w_jisr;
    assign il        = w_il;

endmodule : interrupt_spr_unit
`default_nettype wire

// File: tb/tb_interrupt_spr_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_spr_unit
// Description : Self-checking bench for interrupt_spr_unit. A register-array
//               reference model is compared against the DUT on every falling
//               edge. Directed scenarios pin the model with literal values,
//               and a randomized phase follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_spr_unit;

    logic        clk;
    logic        rst_n;
    logic [22:0] ca;
    logic [31:0] pc, next_pc, ea;
    logic        rpt, eret, spr_we;
    logic [2:0]  spr_addr;
    logic [31:0] spr_wdata;
    logic [31:0] spr_rdata, sr_out, esr_out, eca_out, epc_out, edata_out, pto, ptl;
    logic        mode_out;
    logic [22:0] mca;
    logic        jisr;
    logic [4:0]  il;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: index 0..6 = SR,ESR,ECA,EPC,EDATA,PTO,PTL; 7 = MODE (bit 0)
    logic [31:0] m_spr [0:7];

    interrupt_spr_unit dut (
        .clk(clk), .rst_n(rst_n), .ca(ca), .pc(pc), .next_pc(next_pc), .ea(ea),
        .rpt(rpt), .eret(eret), .spr_we(spr_we), .spr_addr(spr_addr),
        .spr_wdata(spr_wdata), .spr_rdata(spr_rdata), .sr_out(sr_out),
        .esr_out(esr_out), .eca_out(eca_out), .epc_out(epc_out),
        .edata_out(edata_out), .pto(pto), .ptl(ptl), .mode_out(mode_out),
        .mca(mca), .jisr(jisr), .il(il)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int k = 0; k < 8; k++) m_spr[k] = '0;
    endtask

    // Causes 0..5 always pass; higher causes need the matching SR bit.
    function automatic logic [22:0] exp_mca();
        return ca & (m_spr[0][22:0] | 23'h00003F);
    endfunction

    function automatic logic [4:0] exp_il();
        logic [22:0] m;
        m = exp_mca();
        for (int j = 0; j < 23; j++) if (m[j]) return 5'(j);
        return 5'd0;
    endfunction

    // Single compare process: check the outputs, then advance the model for the coming edge.
    always @(negedge clk) begin
        logic [22:0] em;
        em = exp_mca();
        check("mca", {9'b0, mca}, {9'b0, em});
        check("jisr", {31'b0, jisr}, {31'b0, (em != 0)});
        check("il", {27'b0, il}, {27'b0, exp_il()});
        check("sr", sr_out, m_spr[0]);
        check("esr", esr_out, m_spr[1]);
        check("eca", eca_out, m_spr[2]);
        check("epc", epc_out, m_spr[3]);
        check("edata", edata_out, m_spr[4]);
        check("pto", pto, m_spr[5]);
        check("ptl", ptl, m_spr[6]);
        check("mode", {31'b0, mode_out}, m_spr[7]);
        check("rdata", spr_rdata, m_spr[spr_addr]);
        if (rst_n) begin
            if (em != 0) begin
                m_spr[1] = m_spr[0];
                m_spr[0] = 0;
                m_spr[2] = {9'b0, em};
                m_spr[3] = rpt ? pc : next_pc;
                m_spr[4] = ea;
                m_spr[7] = 0;
            end else if (eret) begin
                m_spr[0] = m_spr[1];
                m_spr[7] = 1;
            end else if (spr_we) begin
                m_spr[spr_addr] = (spr_addr == 3'd7) ? {31'b0, spr_wdata[0]} : spr_wdata;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ca = '0; eret = 0; spr_we = 0; spr_addr = '0; spr_wdata = '0; rpt = 0;
    endtask

    task automatic spr_write(input logic [2:0] a, input logic [31:0] d);
        spr_we = 1; spr_addr = a; spr_wdata = d;
        tick();
        spr_we = 0; spr_addr = '0;
    endtask

    initial begin
        reset_model();
        rst_n = 0; idle(); pc = '0; next_pc = '0; ea = '0;
        #12;
        rst_n = 1;
        tick();

        // 1. Idle after reset: every SPR reads zero
        for (int a = 0; a < 8; a++) begin
            spr_addr = 3'(a);
            #1 check("t1_rdata", spr_rdata, 32'h0);
            tick();
        end
        spr_addr = '0;
        check("t1_jisr", {31'b0, jisr}, 32'h0);
        check("t1_il", {27'b0, il}, 32'h0);
        check("t1_mode", {31'b0, mode_out}, 32'h0);

        // 2. Masked overflow, then enabled by SR
        ca = 23'h40;
        #1 check("t2_mca_masked", {9'b0, mca}, 32'h0);
        check("t2_jisr_masked", {31'b0, jisr}, 32'h0);
        tick();
        ca = '0;
        spr_write(3'd0, 32'h40);
        ca = 23'h40; pc = 32'h100; next_pc = 32'h104; rpt = 0; ea = 32'h55;
        #1 check("t2_jisr", {31'b0, jisr}, 32'h1);
        check("t2_il", {27'b0, il}, 32'd6);
        tick();
        ca = '0;
        #1 check("t2_epc", epc_out, 32'h104);
        check("t2_eca", eca_out, 32'h40);
        check("t2_esr", esr_out, 32'h40);
        check("t2_sr", sr_out, 32'h0);
        check("t2_edata", edata_out, 32'h55);

        // 3. Two unmaskable causes, repeat type
        ca = 23'h000024; rpt = 1; pc = 32'h200;
        #1 check("t3_jisr", {31'b0, jisr}, 32'h1);
        check("t3_il", {27'b0, il}, 32'd2);
        tick();
        ca = '0; rpt = 0;
        #1 check("t3_epc", epc_out, 32'h200);
        check("t3_eca", eca_out, 32'h24);
        check("t3_mode", {31'b0, mode_out}, 32'h0);

        // 4. eret restores SR from ESR, then an external interrupt is taken
        spr_write(3'd1, 32'hFFC0);
        eret = 1;
        tick();
        eret = 0;
        #1 check("t4_sr", sr_out, 32'hFFC0);
        check("t4_mode", {31'b0, mode_out}, 32'h1);
        ca = 23'h400;
        #1 check("t4_jisr", {31'b0, jisr}, 32'h1);
        check("t4_il", {27'b0, il}, 32'd10);
        tick();
        ca = '0;
        #1 check("t4_mode_after", {31'b0, mode_out}, 32'h0);
        check("t4_esr", esr_out, 32'hFFC0);

        // 5. jisr + eret + spr_we together: only the interrupt entry happens
        spr_write(3'd5, 32'hA5A5);
        ca = 23'h1; eret = 1; spr_we = 1; spr_addr = 3'd5; spr_wdata = 32'hDEAD;
        tick();
        idle();
        #1 check("t5_pto", pto, 32'hA5A5);
        check("t5_mode", {31'b0, mode_out}, 32'h0);
        check("t5_eca", eca_out, 32'h1);

        // 6. Asynchronous reset between edges
        spr_write(3'd5, 32'h11);
        spr_write(3'd6, 32'h22);
        #1 check("t6_pto_prog", pto, 32'h11);
        check("t6_ptl_prog", ptl, 32'h22);
        rst_n = 0; reset_model(); ca = 23'h82;
        #1 check("t6_pto", pto, 32'h0);
        check("t6_ptl", ptl, 32'h0);
        check("t6_sr", sr_out, 32'h0);
        check("t6_mode", {31'b0, mode_out}, 32'h0);
        check("t6_mca", {9'b0, mca}, 32'h2);
        tick();
        rst_n = 1; idle();
        tick();

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            ca        = ($urandom_range(0, 2) == 0) ? 23'($urandom) : 23'h0;
            if ($urandom_range(0, 3) == 0) ca = ca & 23'h7FFFC0;
            pc        = $urandom;
            next_pc   = $urandom;
            ea        = $urandom;
            rpt       = 1'($urandom);
            eret      = ($urandom_range(0, 7) == 0);
            spr_we    = ($urandom_range(0, 2) == 0);
            spr_addr  = 3'($urandom);
            spr_wdata = $urandom;
            if ($urandom_range(0, 249) == 0) begin
                #2 rst_n = 0;
                reset_model();
                tick();
                rst_n = 1;
            end else begin
                tick();
            end
        end

        idle();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_interrupt_spr_unit
`default_nettype wire
